title_ram_writer: RTL

Write-side engine for the title/sprite block RAM. It accepts rectangle-fill commands over a valid/ready handshake and emits one RAM write per clock. Writes use the same {row, column} concatenated address the colorizers read with. It sits between game/menu control logic and the RAM write port, so title and overlay content can be drawn at run time instead of only preloaded from a .mem file.

---
 rtl/title_pkg.sv | 25 ++
 rtl/title_ram_writer_if.sv | 34 +++
 rtl/title_extent_clip.sv | 16 +
 rtl/title_ram_writer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/title_pkg.sv
// Shared title/sprite RAM constants and types.
// Used by the colorizers (read side) and the RAM writer.
package title_pkg;

    localparam int TITLE_ADDR_WIDTH_X = 8;
    localparam int TITLE_ADDR_WIDTH_Y = 7;
    localparam int TITLE_WIDTH        = 1 << TITLE_ADDR_WIDTH_X;
    localparam int TITLE_HEIGHT       = 1 << TITLE_ADDR_WIDTH_Y;
    localparam int COLOR_WIDTH        = 12;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } title_state_t;

    typedef struct packed {
        logic [TITLE_ADDR_WIDTH_X-1:0] x0;
        logic [TITLE_ADDR_WIDTH_Y-1:0] y0;
        logic [TITLE_ADDR_WIDTH_X:0]   w;
        logic [TITLE_ADDR_WIDTH_Y:0]   h;
        logic [COLOR_WIDTH-1:0]        color;
    } title_cmd_t;

endpackage

// File: rtl/title_ram_writer_if.sv
// Command handshake and RAM write port of the title RAM writer.
// master = control logic side, slave = the writer engine.
interface title_ram_writer_if #(
    parameter int ADDR_WIDTH_X = title_pkg::TITLE_ADDR_WIDTH_X,
    parameter int ADDR_WIDTH_Y = title_pkg::TITLE_ADDR_WIDTH_Y,
    parameter int DATA_WIDTH   = title_pkg::COLOR_WIDTH
);

    localparam int ADDR_WIDTH = ADDR_WIDTH_X + ADDR_WIDTH_Y;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH_X-1:0] cmd_x0;
    logic [ADDR_WIDTH_Y-1:0] cmd_y0;
    logic [ADDR_WIDTH_X:0]   cmd_w;
    logic [ADDR_WIDTH_Y:0]   cmd_h;
    logic [DATA_WIDTH-1:0]   cmd_color;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    busy;
    logic                    done;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );

endinterface

// File: rtl/title_extent_clip.sv
// Clips a requested extent so origin + extent never passes 2^W.
// Purely combinational; one instance per axis.
module title_extent_clip #(
    parameter int W = 8
) (
    input  logic [W-1:0] origin,
    input  logic [W:0]   req,
    output logic [W:0]   eff
);

    logic [W:0] avail;

    assign avail = {1'b1, {W{1'b0}}} - {1'b0, origin};
    assign eff   = (req < avail) ? req : avail;

endmodule

// File: rtl/title_ram_writer.sv
// Rectangle-fill write engine for the title/sprite block RAM.
// One raster-order write per clock, addressed as {row, col}.
module title_ram_writer
    import title_pkg::*;
#(
    parameter int ADDR_WIDTH_X = TITLE_ADDR_WIDTH_X,
    parameter int ADDR_WIDTH_Y = TITLE_ADDR_WIDTH_Y,
    parameter int DATA_WIDTH   = COLOR_WIDTH
) (
    input logic              clk,
    input logic              reset,
    title_ram_writer_if.slave bus
);

    localparam int ADDR_WIDTH = ADDR_WIDTH_X + ADDR_WIDTH_Y;
    localparam logic [ADDR_WIDTH_X-1:0] ONE_X = 1;
    localparam logic [ADDR_WIDTH_Y-1:0] ONE_Y = 1;

    title_state_t state;

    logic [ADDR_WIDTH_X:0]   w_eff;
    logic [ADDR_WIDTH_Y:0]   h_eff;
    logic [ADDR_WIDTH_X-1:0] x0;
    logic [ADDR_WIDTH_X-1:0] col;
    logic [ADDR_WIDTH_X-1:0] last_col;
    logic [ADDR_WIDTH_Y-1:0] row;
    logic [ADDR_WIDTH_Y-1:0] last_row;
    logic [DATA_WIDTH-1:0]   color;

    logic                    cmd_ready_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    done_q;

    logic                    accept;
    logic                    zero_extent;
    logic                    end_of_row;
    logic                    last_px;
    logic [ADDR_WIDTH_X-1:0] col_nxt;
    logic [ADDR_WIDTH_Y-1:0] row_nxt;

    title_extent_clip #(.W(ADDR_WIDTH_X)) u_clip_x (
        .origin (bus.cmd_x0),
        .req    (bus.cmd_w),
        .eff    (w_eff)
    );

    title_extent_clip #(.W(ADDR_WIDTH_Y)) u_clip_y (
        .origin (bus.cmd_y0),
        .req    (bus.cmd_h),
        .eff    (h_eff)
    );

    assign accept      = (state == IDLE) && cmd_ready_q && bus.cmd_valid;
    assign zero_extent = (w_eff == '0) || (h_eff == '0);
    assign end_of_row  = (col == last_col);
    assign last_px     = end_of_row && (row == last_row);

    always_comb begin
        col_nxt = col + ONE_X;
        row_nxt = row;
        if (end_of_row) begin
            col_nxt = x0;
            row_nxt = row + ONE_Y;
        end
    end

    // Output registers always hold the pixel being written this cycle,
    // so the first write appears the cycle after the accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        x0          <= bus.cmd_x0;
                        col         <= bus.cmd_x0;
                        row         <= bus.cmd_y0;
                        color       <= bus.cmd_color;
                        // Clipped extents keep these within range, no wrap.
                        last_col    <= bus.cmd_x0 + w_eff[ADDR_WIDTH_X-1:0] - ONE_X;
                        last_row    <= bus.cmd_y0 + h_eff[ADDR_WIDTH_Y-1:0] - ONE_Y;
                        if (zero_extent) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= FILL;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {bus.cmd_y0, bus.cmd_x0};
                            wr_data_q <= bus.cmd_color;
                        end
                    end
                end
                FILL: begin
                    if (last_px) begin
                        state   <= DONE;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        col       <= col_nxt;
                        row       <= row_nxt;
                        wr_addr_q <= {row_nxt, col_nxt};
                        wr_data_q <= color;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    wr_en_q     <= 1'b0;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);

endmodule
